// File: rtl/imem_fetch_arbiter_if.sv
// Bus bundle for imem_fetch_arbiter: two request/response ports plus the
// byte-wide instruction-memory read port.
interface imem_fetch_arbiter_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int WIDTH         = 8
);
    logic                     req0_valid;
    logic [ADDRESS_WIDTH-1:0] req0_addr;
    logic                     req0_ready;
    logic                     rsp0_valid;
    logic [31:0]              rsp0_data;

    logic                     req1_valid;
    logic [ADDRESS_WIDTH-1:0] req1_addr;
    logic                     req1_ready;
    logic                     rsp1_valid;
    logic [31:0]              rsp1_data;

    logic                     mem_en;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]         mem_data;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_addr,
        output req0_ready, rsp0_valid, rsp0_data,
        input  req1_valid, req1_addr,
        output req1_ready, rsp1_valid, rsp1_data,
        output mem_en, mem_addr,
        input  mem_data
    );

    // Requester / memory side
    modport master (
        output req0_valid, req0_addr,
        input  req0_ready, rsp0_valid, rsp0_data,
        output req1_valid, req1_addr,
        input  req1_ready, rsp1_valid, rsp1_data,
        input  mem_en, mem_addr,
        output mem_data
    );
endinterface

// File: rtl/imem_fetch_arbiter.sv
// Round-robin arbiter sharing one byte-wide synchronous ROM port between two
// requesters; each grant reads four bytes and assembles a big-endian word.
module imem_fetch_arbiter #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int WIDTH         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    imem_fetch_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               k_q, k_d;
    logic [ADDRESS_WIDTH-1:0] base_q, base_d;
    logic                     owner_q, owner_d;
    logic                     last_grant_q, last_grant_d;
    logic [31:0]              word_q, word_d;

    logic                     grant_vld;
    logic                     grant;
    logic                     ready0, ready1;
    logic                     rsp0, rsp1;
    logic                     mem_en;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic                     cap_en;
    logic [1:0]               cap_idx;
    logic [WIDTH-1:0]         rd_byte;

    assign rd_byte = bus.mem_data;

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        base_d       = base_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        word_d       = word_q;
        grant_vld    = 1'b0;
        grant        = 1'b0;
        ready0       = 1'b0;
        ready1       = 1'b0;
        rsp0         = 1'b0;
        rsp1         = 1'b0;
        mem_en       = 1'b0;
        mem_addr     = '0;
        cap_en       = 1'b0;
        cap_idx      = 2'd3;

        case (state_q)
            S_IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    grant_vld = 1'b1;
                    grant     = ~last_grant_q;
                end else if (bus.req0_valid) begin
                    grant_vld = 1'b1;
                    grant     = 1'b0;
                end else if (bus.req1_valid) begin
                    grant_vld = 1'b1;
                    grant     = 1'b1;
                end
                // Ready is gated by rst_n so it reads 0 while reset is held
                ready0 = rst_n && grant_vld && !grant;
                ready1 = rst_n && grant_vld && grant;
                if (grant_vld) begin
                    base_d       = grant ? bus.req1_addr : bus.req0_addr;
                    owner_d      = grant;
                    last_grant_d = grant;
                    k_d          = 2'd0;
                    state_d      = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_en   = 1'b1;
                mem_addr = base_q + ADDRESS_WIDTH'(k_q);
                k_d      = 2'(k_q + 2'd1);
                // Byte k-1 returns while byte k is being issued
                if (k_q != 2'd0) begin
                    cap_en  = 1'b1;
                    cap_idx = 2'(k_q - 2'd1);
                end
                if (k_q == 2'd3) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                cap_en  = 1'b1;
                cap_idx = 2'd3;
                state_d = S_RESP;
            end
            S_RESP: begin
                rsp0    = !owner_q;
                rsp1    = owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (cap_en) begin
            case (cap_idx)
                2'd0:    word_d[31:24] = rd_byte;
                2'd1:    word_d[23:16] = rd_byte;
                2'd2:    word_d[15:8]  = rd_byte;
                default: word_d[7:0]   = rd_byte;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            k_q          <= 2'd0;
            base_q       <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            word_q       <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            base_q       <= base_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            word_q       <= word_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp0_valid = rsp0;
    assign bus.rsp1_valid = rsp1;
    assign bus.rsp0_data  = word_q;
    assign bus.rsp1_data  = word_q;
    assign bus.mem_en     = mem_en;
    assign bus.mem_addr   = mem_addr;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter: a byte ROM model answers mem reads
// one cycle later; inputs change 1 time unit after the rising edge.
module tb_imem_fetch_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] rom [256];
    logic [7:0] wrap_addr [4];
    int   seen0;

    always #5 clk = ~clk;

    imem_fetch_arbiter_if #(.ADDRESS_WIDTH(8), .WIDTH(8)) bus ();

    imem_fetch_arbiter #(.ADDRESS_WIDTH(8), .WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always @(posedge clk) begin
        if (bus.mem_en) bus.mem_data <= rom[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 8'h00;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = 8'h00;

        // Reset values (req0 held valid so ready gating is visible)
        #12;
        chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
        chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        chk("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        chk("rst_word", bus.rsp0_data, 32'd0);
        bus.req0_valid = 1'b0;
        rst_n = 1'b1;
        tick(1);

        // 1: basic fetch
        rom[0] = 8'h13; rom[1] = 8'h05; rom[2] = 8'h00; rom[3] = 8'h00;
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 8'h00;
        #1;
        chk("t1_ready0", 32'(bus.req0_ready), 32'd1);
        chk("t1_ready1", 32'(bus.req1_ready), 32'd0);
        tick(1);
        bus.req0_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t1_mem_en", 32'(bus.mem_en), 32'd1);
            chk("t1_mem_addr", 32'(bus.mem_addr), 32'(k));
            tick(1);
        end
        #1;
        chk("t1_drain_mem_en", 32'(bus.mem_en), 32'd0);
        chk("t1_early_rsp0", 32'(bus.rsp0_valid), 32'd0);
        tick(1);
        #1;
        chk("t1_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        chk("t1_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        chk("t1_rsp0_data", bus.rsp0_data, 32'h13050000);
        tick(1);

        // 2: tie arbitration after reset
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        rom[8'h10] = 8'hDE; rom[8'h11] = 8'hAD; rom[8'h12] = 8'hBE; rom[8'h13] = 8'hEF;
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 8'h00;
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 8'h10;
        for (int t = 0; t < 4; t++) begin
            #1;
            chk("t2_ready0", 32'(bus.req0_ready), 32'(t % 2 == 0));
            chk("t2_ready1", 32'(bus.req1_ready), 32'(t % 2 == 1));
            tick(3);
            chk("t2_busy_ready0", 32'(bus.req0_ready), 32'd0);
            chk("t2_busy_ready1", 32'(bus.req1_ready), 32'd0);
            tick(3);
            chk("t2_rsp0_valid", 32'(bus.rsp0_valid), 32'(t % 2 == 0));
            chk("t2_rsp1_valid", 32'(bus.rsp1_valid), 32'(t % 2 == 1));
            chk("t2_rsp_data", bus.rsp0_data, (t % 2 == 1) ? 32'hDEADBEEF : 32'h13050000);
            tick(1);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // 3: address wrap
        rom[8'hFE] = 8'hAA; rom[8'hFF] = 8'hBB; rom[8'h00] = 8'hCC; rom[8'h01] = 8'hDD;
        wrap_addr[0] = 8'hFE; wrap_addr[1] = 8'hFF; wrap_addr[2] = 8'h00; wrap_addr[3] = 8'h01;
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 8'hFE;
        #1;
        chk("t3_ready0", 32'(bus.req0_ready), 32'd1);
        tick(1);
        bus.req0_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_mem_addr", 32'(bus.mem_addr), 32'(wrap_addr[k]));
            tick(1);
        end
        tick(1);
        chk("t3_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        chk("t3_rsp0_data", bus.rsp0_data, 32'hAABBCCDD);
        tick(1);

        // 4: busy blocking
        rom[8'h20] = 8'h11; rom[8'h21] = 8'h22; rom[8'h22] = 8'h33; rom[8'h23] = 8'h44;
        rom[8'h30] = 8'h55; rom[8'h31] = 8'h66; rom[8'h32] = 8'h77; rom[8'h33] = 8'h88;
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 8'h20;
        #1;
        chk("t4_ready0", 32'(bus.req0_ready), 32'd1);
        tick(1);
        bus.req0_valid = 1'b0;
        tick(1);
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 8'h30;
        for (int c = 2; c <= 6; c++) begin
            #1;
            chk("t4_blocked_ready1", 32'(bus.req1_ready), 32'd0);
            tick(1);
        end
        tick(0);
        chk("t4_ready1", 32'(bus.req1_ready), 32'd1);
        chk("t4_ready0", 32'(bus.req0_ready), 32'd0);
        tick(1);
        bus.req1_valid = 1'b0;
        #1;
        chk("t4_hold_c8", bus.rsp1_data, 32'h11223344);
        tick(1);
        chk("t4_hold_c9", bus.rsp1_data, 32'h11223344);
        tick(1);
        chk("t4_partial_c10", bus.rsp1_data, 32'h55223344);
        tick(3);
        chk("t4_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
        chk("t4_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        chk("t4_rsp1_data", bus.rsp1_data, 32'h55667788);
        tick(1);

        // 5: reset during FETCH k=2
        rom[4] = 8'h01; rom[5] = 8'h02; rom[6] = 8'h03; rom[7] = 8'h04;
        seen0 = 0;
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 8'h20;
        #1;
        chk("t5_ready0", 32'(bus.req0_ready), 32'd1);
        tick(1);
        bus.req0_valid = 1'b0;
        tick(2);
        chk("t5_mem_addr_k2", 32'(bus.mem_addr), 32'h22);
        rst_n = 1'b0;
        #1;
        chk("t5_abort_mem_en", 32'(bus.mem_en), 32'd0);
        chk("t5_abort_word", bus.rsp0_data, 32'd0);
        tick(1);
        rst_n = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 8'h04;
        #1;
        chk("t5_ready1_first", 32'(bus.req1_ready), 32'd1);
        tick(1);
        bus.req1_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            #1;
            if (bus.rsp0_valid) seen0++;
            if (c < 6) tick(1);
        end
        chk("t5_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
        chk("t5_rsp1_data", bus.rsp1_data, 32'h01020304);
        chk("t5_no_rsp0", 32'(seen0), 32'd0);
        tick(1);

        // 6: withdrawn request during a port 0 transaction
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 8'h00;
        #1;
        chk("t6_ready0", 32'(bus.req0_ready), 32'd1);
        tick(1);
        bus.req0_valid = 1'b0;
        tick(2);
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 8'h30;
        #1;
        chk("t6_busy_ready1", 32'(bus.req1_ready), 32'd0);
        tick(1);
        bus.req1_valid = 1'b0;
        tick(2);
        chk("t6_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        chk("t6_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        chk("t6_rsp0_data", bus.rsp0_data, 32'hCCDD0000);
        tick(1);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("t6_tie_ready1", 32'(bus.req1_ready), 32'd1);
        chk("t6_tie_ready0", 32'(bus.req0_ready), 32'd0);
        tick(1);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick(5);
        chk("t6_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
        chk("t6_rsp1_data", bus.rsp1_data, 32'h55667788);
        tick(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
